// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM duty sequencer: mode values, FSM state codes
// and the entry-state mapping used when a new mode is latched.
package pwm_pkg;

  localparam int DEFAULT_DUTY_W  = 4;
  localparam int DEFAULT_PRESC_W = 8;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_HOLD    = 2'b01;
  localparam logic [1:0] MODE_RAMP    = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_TOP  = 3'd4;

  // Both ramp modes start climbing from zero; breathe only differs at the top.
  function automatic logic [2:0] entry_state(input logic [1:0] m);
    logic [2:0] s;
    case (m)
      MODE_OFF:  s = S_OFF;
      MODE_HOLD: s = S_HOLD;
      default:   s = S_UP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running PWM frame counter plus the frame prescaler that turns every
// step_div-th frame boundary into a ramp step.
module pwm_frame_timer
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DEFAULT_DUTY_W,
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear_presc,
  input  logic [PRESC_W-1:0] step_div,
  output logic [DUTY_W-1:0]  frame_cnt,
  output logic               frame_tick,
  output logic               step
);

  localparam logic [DUTY_W-1:0] CNT_MAX = '1;

  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] last_pcnt;

  // A divider of zero is treated as one step per frame.
  assign last_pcnt  = (step_div == '0) ? '0 : step_div - PRESC_W'(1);
  assign frame_tick = en && (frame_cnt == CNT_MAX);
  assign step       = frame_tick && (pcnt == last_pcnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      pcnt      <= '0;
    end else if (en) begin
      frame_cnt <= frame_cnt + DUTY_W'(1);
      if (frame_tick) begin
        if (clear_presc || step)
          pcnt <= '0;
        else
          pcnt <= pcnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Duty-cycle sequencer for the PWM datapath: off / hold / one-shot ramp /
// breathe, with every duty and mode update aligned to a frame boundary.
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DEFAULT_DUTY_W,
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [DUTY_W-1:0]  hold_duty,
  input  logic [PRESC_W-1:0] step_div,
  output logic [DUTY_W-1:0]  duty_cycle,
  output logic               pwm_gate,
  output logic [DUTY_W-1:0]  frame_cnt,
  output logic               frame_tick,
  output logic               busy,
  output logic               done
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  logic [2:0] state;
  logic [1:0] mode_q;
  logic       done_q;
  logic       step;
  logic       mode_change;

  assign mode_change = frame_tick && (mode != mode_q);

  pwm_frame_timer #(
    .DUTY_W  (DUTY_W),
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear_presc (mode_change),
    .step_div    (step_div),
    .frame_cnt   (frame_cnt),
    .frame_tick  (frame_tick),
    .step        (step)
  );

  // A mode change wins over any step that lands on the same boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OFF;
      mode_q     <= MODE_OFF;
      duty_cycle <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mode_change) begin
        mode_q     <= mode;
        state      <= entry_state(mode);
        duty_cycle <= (mode == MODE_HOLD) ? hold_duty : '0;
      end else if (frame_tick) begin
        case (state)
          S_OFF: duty_cycle <= '0;
          S_HOLD: duty_cycle <= hold_duty;
          S_UP: begin
            if (step) begin
              if (duty_cycle != DUTY_MAX) begin
                duty_cycle <= duty_cycle + DUTY_W'(1);
              end else if (mode_q == MODE_RAMP) begin
                state  <= S_TOP;
                done_q <= 1'b1;
              end else begin
                state      <= S_DOWN;
                duty_cycle <= duty_cycle - DUTY_W'(1);
              end
            end
          end
          S_DOWN: begin
            if (step) begin
              if (duty_cycle != '0) begin
                duty_cycle <= duty_cycle - DUTY_W'(1);
              end else begin
                state      <= S_UP;
                duty_cycle <= duty_cycle + DUTY_W'(1);
              end
            end
          end
          S_TOP: duty_cycle <= DUTY_MAX;
          default: begin
            state      <= S_OFF;
            duty_cycle <= '0;
          end
        endcase
      end
    end
  end

  // Gating with en keeps a pending pulse from appearing while frozen.
  assign done     = done_q && en;
  assign pwm_gate = (state != S_OFF);
  assign busy     = (state == S_UP) || (state == S_DOWN);

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer: reset, hold, one-shot ramp, breathe,
// enable freeze and asynchronous reset, with hand-derived expectations.
module tb_pwm_fade_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] hold_duty;
  logic [7:0] step_div;
  logic [3:0] duty_cycle;
  logic       pwm_gate;
  logic [3:0] frame_cnt;
  logic       frame_tick;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  pwm_fade_sequencer #(.DUTY_W(4), .PRESC_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .hold_duty  (hold_duty),
    .step_div   (step_div),
    .duty_cycle (duty_cycle),
    .pwm_gate   (pwm_gate),
    .frame_cnt  (frame_cnt),
    .frame_tick (frame_tick),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full frame from a frame_cnt==0 sample to the next, counting done pulses.
  task automatic run_frame(output int pulses);
    pulses = 0;
    repeat (16) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  function automatic int triangle(input int k);
    int r;
    r = k % 30;
    return (r <= 15) ? r : 30 - r;
  endfunction

  initial begin
    int p;

    reset     = 1'b1;
    en        = 1'b1;
    mode      = 2'b00;
    hold_duty = 4'd0;
    step_div  = 8'd0;

    // Reset state
    wait_cycles(3);
    check_output("rst_duty", duty_cycle, 0);
    check_output("rst_gate", pwm_gate, 0);
    check_output("rst_cnt", frame_cnt, 0);
    check_output("rst_tick", frame_tick, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    reset = 1'b0;

    // Off mode: tick only on the last count of each 16-cycle frame
    wait_cycles(14);
    check_output("off_tick14", frame_tick, 0);
    wait_cycles(1);
    check_output("off_cnt15", frame_cnt, 15);
    check_output("off_tick15", frame_tick, 1);
    wait_cycles(1);
    check_output("off_wrap", frame_cnt, 0);
    check_output("off_tick0", frame_tick, 0);
    check_output("off_duty", duty_cycle, 0);
    check_output("off_gate", pwm_gate, 0);
    wait_cycles(15);
    check_output("off_tick2", frame_tick, 1);
    wait_cycles(1);

    // Hold mode selected mid-frame
    wait_cycles(5);
    mode      = 2'b01;
    hold_duty = 4'd9;
    wait_cycles(10);
    check_output("hold_early_duty", duty_cycle, 0);
    check_output("hold_early_gate", pwm_gate, 0);
    wait_cycles(1);
    check_output("hold_duty9", duty_cycle, 9);
    check_output("hold_gate", pwm_gate, 1);
    check_output("hold_busy", busy, 0);
    wait_cycles(3);
    hold_duty = 4'd3;
    wait_cycles(12);
    check_output("hold_still9", duty_cycle, 9);
    wait_cycles(1);
    check_output("hold_duty3", duty_cycle, 3);

    // One-shot ramp, two frames per step
    mode     = 2'b10;
    step_div = 8'd2;
    run_frame(p);
    check_output("ramp_pre_done", p, 0);
    for (int f = 0; f < 32; f++) begin
      check_output("ramp_duty", duty_cycle, f / 2);
      check_output("ramp_busy", busy, 1);
      run_frame(p);
      check_output("ramp_done_cnt", p, (f == 31) ? 1 : 0);
    end
    check_output("top_duty", duty_cycle, 15);
    check_output("top_busy", busy, 0);
    check_output("top_done", done, 1);
    run_frame(p);
    check_output("top_done_once", p, 0);
    check_output("top_hold15", duty_cycle, 15);
    check_output("top_gate", pwm_gate, 1);

    // Breathe with step_div=0 acting as 1
    mode     = 2'b11;
    step_div = 8'd0;
    run_frame(p);
    check_output("br_entry_done", p, 0);
    for (int k = 0; k < 37; k++) begin
      check_output("br_duty", duty_cycle, triangle(k));
      check_output("br_busy", busy, 1);
      run_frame(p);
      check_output("br_no_done", p, 0);
    end
    check_output("br_duty7", duty_cycle, 7);

    // Freeze with en=0 at frame_cnt==4
    wait_cycles(4);
    en = 1'b0;
    wait_cycles(40);
    check_output("frz_cnt", frame_cnt, 4);
    check_output("frz_duty", duty_cycle, 7);
    check_output("frz_tick", frame_tick, 0);
    check_output("frz_busy", busy, 1);
    en = 1'b1;
    wait_cycles(11);
    check_output("frz_tick15", frame_tick, 1);
    check_output("frz_duty_hold", duty_cycle, 7);
    wait_cycles(1);
    check_output("frz_resume_cnt", frame_cnt, 0);
    check_output("frz_resume_duty", duty_cycle, 8);

    // Breathe -> one-shot is a mode change: ramp restarts from zero
    mode = 2'b10;
    run_frame(p);
    check_output("sw_duty0", duty_cycle, 0);
    run_frame(p);
    check_output("sw_duty1", duty_cycle, 1);
    run_frame(p);
    check_output("sw_duty2", duty_cycle, 2);

    // Asynchronous reset mid-ramp
    wait_cycles(5);
    reset = 1'b1;
    #1;
    check_output("arst_duty", duty_cycle, 0);
    check_output("arst_gate", pwm_gate, 0);
    check_output("arst_busy", busy, 0);
    check_output("arst_cnt", frame_cnt, 0);
    mode = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(16);
    check_output("re_hold_duty", duty_cycle, 3);
    check_output("re_hold_gate", pwm_gate, 1);
    mode = 2'b10;
    wait_cycles(16);
    check_output("re_ramp_duty0", duty_cycle, 0);
    check_output("re_ramp_busy", busy, 1);
    wait_cycles(16);
    check_output("re_ramp_duty1", duty_cycle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
